// File: rtl/icm_lookup_responder_pkg.sv
// Shared ICM/physical address-space constants and the mapping-table entry layout.
// Imported by the responder top, its interface and the table RAM.
package icm_lookup_responder_pkg;

   localparam int ICM_SPACE_ADDR_WIDTH = 64;
   localparam int PHY_SPACE_ADDR_WIDTH = 64;
   localparam int ICM_ENTRY_NUM_MPT    = 1024;
   localparam int ICM_ENTRY_NUM_CQC    = 512;
   localparam int ICM_ENTRY_NUM_QPC    = 1024;
   localparam int DEF_ICM_PAGE_SHIFT   = 12;

   // Table word: valid flag sits directly above the physical page address.
   typedef struct packed {
      logic                            valid;
      logic [PHY_SPACE_ADDR_WIDTH-1:0] phy_addr;
   } icm_entry_t;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } map_state_t;

endpackage

// File: rtl/icm_lookup_responder_if.sv
// Lookup channel plus mapping-update channel between the ICM arbiter/write path and the responder.
// No rsp_ready and no lookup_ready: the responder sinks one lookup and emits one response per cycle.
interface icm_lookup_responder_if #(
   parameter int HEAD_WIDTH     = 10,
   parameter int ICM_ADDR_WIDTH = 64,
   parameter int PHY_ADDR_WIDTH = 64
);
   logic                      lookup_valid;
   logic [HEAD_WIDTH-1:0]     lookup_head;
   logic                      rsp_valid;
   logic [ICM_ADDR_WIDTH-1:0] rsp_icm_addr;
   logic [PHY_ADDR_WIDTH-1:0] rsp_phy_addr;
   logic                      rsp_hit;
   logic                      map_wr_valid;
   logic                      map_wr_set;
   logic [HEAD_WIDTH-1:0]     map_wr_head;
   logic [PHY_ADDR_WIDTH-1:0] map_wr_phy_addr;
   logic                      map_wr_ready;
   logic                      init_done;

   modport master (
      output lookup_valid, lookup_head,
      input  rsp_valid, rsp_icm_addr, rsp_phy_addr, rsp_hit,
      output map_wr_valid, map_wr_set, map_wr_head, map_wr_phy_addr,
      input  map_wr_ready, init_done
   );

   modport slave (
      input  lookup_valid, lookup_head,
      output rsp_valid, rsp_icm_addr, rsp_phy_addr, rsp_hit,
      input  map_wr_valid, map_wr_set, map_wr_head, map_wr_phy_addr,
      output map_wr_ready, init_done
   );
endinterface

// File: rtl/icm_lookup_responder_ram.sv
// Simple dual-port mapping table: one write port, one read port with 1-cycle registered read.
// Contents are not reset; read-during-write to the same address returns don't-care data.
module icm_map_table_ram #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH),
   parameter int DATA_W = 65
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_dat,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_dat
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
      rd_dat <= mem[rd_addr];
   end

endmodule

// File: rtl/icm_lookup_responder.sv
// ICM page -> physical page lookup responder; fixed 2-cycle latency, one lookup per cycle.
// No backpressure on lookups or responses; updates accepted only after the init sweep.
module icm_lookup_responder
   import icm_lookup_responder_pkg::*;
#(
   parameter int ICM_ENTRY_NUM     = 1024,
   parameter int ICM_ENTRY_NUM_LOG = $clog2(ICM_ENTRY_NUM),
   parameter int ICM_ADDR_WIDTH    = ICM_SPACE_ADDR_WIDTH,
   parameter int PHY_ADDR_WIDTH    = PHY_SPACE_ADDR_WIDTH,
   parameter int ICM_PAGE_SHIFT    = DEF_ICM_PAGE_SHIFT
) (
   input  logic                  clk,
   input  logic                  rst,
   icm_lookup_responder_if.slave bus
);

   localparam int ENTRY_W = PHY_ADDR_WIDTH + 1;
   localparam logic [ICM_ENTRY_NUM_LOG-1:0] INIT_LAST = ICM_ENTRY_NUM_LOG'(ICM_ENTRY_NUM - 1);

   if (ICM_ENTRY_NUM_LOG + ICM_PAGE_SHIFT > ICM_ADDR_WIDTH) begin : g_trunc_warn
      $warning("icm_lookup_responder: page index << page shift exceeds ICM address width, upper bits truncated");
   end

   map_state_t                   state, state_nxt;
   logic [ICM_ENTRY_NUM_LOG-1:0] init_cnt, init_cnt_nxt;
   logic                         wr_en;
   logic [ICM_ENTRY_NUM_LOG-1:0] wr_addr;
   logic [ENTRY_W-1:0]           wr_dat;
   logic [ENTRY_W-1:0]           rd_dat;
   logic                         run;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else begin
         state    <= state_nxt;
         init_cnt <= init_cnt_nxt;
      end
   end

   // The init sweep owns the RAM write port until every entry has been cleared.
   always_comb begin
      state_nxt    = state;
      init_cnt_nxt = init_cnt;
      wr_en        = 1'b0;
      wr_addr      = bus.map_wr_head;
      wr_dat       = '0;
      run          = 1'b0;
      case (state)
         ST_INIT: begin
            wr_en        = 1'b1;
            wr_addr      = init_cnt;
            init_cnt_nxt = init_cnt + 1'b1;
            if (init_cnt == INIT_LAST) begin
               state_nxt    = ST_RUN;
               init_cnt_nxt = '0;
            end
         end
         ST_RUN: begin
            run    = 1'b1;
            wr_en  = bus.map_wr_valid;
            wr_dat = bus.map_wr_set ? {1'b1, bus.map_wr_phy_addr} : '0;
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   assign bus.map_wr_ready = run;
   assign bus.init_done    = run;

   icm_map_table_ram #(
      .DEPTH  (ICM_ENTRY_NUM),
      .ADDR_W (ICM_ENTRY_NUM_LOG),
      .DATA_W (ENTRY_W)
   ) u_table (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_dat  (wr_dat),
      .rd_addr (bus.lookup_head),
      .rd_dat  (rd_dat)
   );

   logic                         s1_vld;
   logic [ICM_ENTRY_NUM_LOG-1:0] s1_head;
   logic                         s1_byp;
   logic [ENTRY_W-1:0]           s1_byp_dat;
   logic                         s1_init;

   // Same-cycle write to the looked-up head wins over the (undefined) RAM read-during-write data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_vld     <= 1'b0;
         s1_head    <= '0;
         s1_byp     <= 1'b0;
         s1_byp_dat <= '0;
         s1_init    <= 1'b0;
      end else begin
         s1_vld     <= bus.lookup_valid;
         s1_head    <= bus.lookup_head;
         s1_byp     <= bus.lookup_valid && wr_en && (wr_addr == bus.lookup_head);
         s1_byp_dat <= wr_dat;
         s1_init    <= (state == ST_INIT);
      end
   end

   logic [ENTRY_W-1:0]        entry_sel;
   logic                      entry_hit;
   logic [ICM_ADDR_WIDTH-1:0] head_ext;

   // Lookups issued during the sweep may read entries not yet cleared, so they are forced to miss.
   assign entry_sel = s1_byp ? s1_byp_dat : rd_dat;
   assign entry_hit = entry_sel[PHY_ADDR_WIDTH] && !s1_init;
   assign head_ext  = ICM_ADDR_WIDTH'(s1_head);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.rsp_valid    <= 1'b0;
         bus.rsp_hit      <= 1'b0;
         bus.rsp_phy_addr <= '0;
         bus.rsp_icm_addr <= '0;
      end else begin
         bus.rsp_valid <= s1_vld;
         if (s1_vld) begin
            bus.rsp_hit      <= entry_hit;
            bus.rsp_phy_addr <= entry_hit ? entry_sel[PHY_ADDR_WIDTH-1:0] : '0;
            bus.rsp_icm_addr <= head_ext << ICM_PAGE_SHIFT;
         end
      end
   end

endmodule

// File: tb/tb_icm_lookup_responder.sv
// Directed bench for icm_lookup_responder with a 16-entry table and 4 KiB pages.
module tb_icm_lookup_responder;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   icm_lookup_responder_if #(
      .HEAD_WIDTH     (4),
      .ICM_ADDR_WIDTH (64),
      .PHY_ADDR_WIDTH (64)
   ) bus ();

   icm_lookup_responder #(
      .ICM_ENTRY_NUM  (16),
      .ICM_ADDR_WIDTH (64),
      .PHY_ADDR_WIDTH (64),
      .ICM_PAGE_SHIFT (12)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic lookup_one(input logic [3:0] head);
      bus.lookup_valid = 1'b1;
      bus.lookup_head  = head;
      tick();
      bus.lookup_valid = 1'b0;
      tick();
   endtask

   task automatic write_one(input logic set, input logic [3:0] head, input logic [63:0] phy);
      bus.map_wr_valid    = 1'b1;
      bus.map_wr_set      = set;
      bus.map_wr_head     = head;
      bus.map_wr_phy_addr = phy;
      tick();
      bus.map_wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      n_vec++;
      if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr, bus.init_done, bus.map_wr_ready} !== 131'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got valid=%b hit=%b phy=%h icm=%h done=%b rdy=%b, want all 0",
                  bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr, bus.init_done, bus.map_wr_ready);
      end
      rst = 1'b1;
      bus.lookup_valid = 1'b1;
      bus.lookup_head  = 4'd5;
      for (int k = 1; k <= 16; k++) begin
         tick();
         bus.lookup_valid = 1'b0;
         n_vec++;
         if ({bus.init_done, bus.map_wr_ready} !== {2{k == 16}}) begin
            n_bad++;
            $display("FAIL init_done cycle %0d: got done=%b rdy=%b, want %b", k, bus.init_done, bus.map_wr_ready, k == 16);
         end
         n_vec++;
         if (k == 2) begin
            if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr} !== {1'b1, 1'b0, 64'd0, 64'h5000}) begin
               n_bad++;
               $display("FAIL init_lookup: got valid=%b hit=%b phy=%h icm=%h, want 1 0 0 5000",
                        bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr);
            end
         end else if (bus.rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL init_rsp_idle cycle %0d: got rsp_valid=%b, want 0", k, bus.rsp_valid);
         end
      end
   endtask

   task automatic test_install();
      write_one(1'b1, 4'd3, 64'hABCD_E000);
      tick();
      lookup_one(4'd3);
      n_vec++;
      if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr} !== {1'b1, 1'b1, 64'hABCD_E000, 64'h3000}) begin
         n_bad++;
         $display("FAIL install_hit: got valid=%b hit=%b phy=%h icm=%h, want 1 1 abcde000 3000",
                  bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr);
      end
      tick();
      n_vec++;
      if ({bus.rsp_valid, bus.rsp_phy_addr} !== {1'b0, 64'hABCD_E000}) begin
         n_bad++;
         $display("FAIL rsp_single_pulse: got valid=%b phy=%h, want 0 abcde000 (held)", bus.rsp_valid, bus.rsp_phy_addr);
      end
   endtask

   task automatic test_miss_invalidate();
      lookup_one(4'd7);
      n_vec++;
      if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr} !== {1'b1, 1'b0, 64'd0, 64'h7000}) begin
         n_bad++;
         $display("FAIL unmapped_7: got valid=%b hit=%b phy=%h icm=%h, want 1 0 0 7000",
                  bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr);
      end
      write_one(1'b0, 4'd3, 64'hFFFF_FFFF);
      lookup_one(4'd3);
      n_vec++;
      if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr} !== {1'b1, 1'b0, 64'd0, 64'h3000}) begin
         n_bad++;
         $display("FAIL invalidate_3: got valid=%b hit=%b phy=%h icm=%h, want 1 0 0 3000",
                  bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr);
      end
   endtask

   task automatic test_bypass();
      bus.lookup_valid = 1'b1;
      bus.lookup_head  = 4'd9;
      write_one(1'b1, 4'd9, 64'h1234_0000);
      bus.lookup_valid = 1'b0;
      tick();
      n_vec++;
      if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr} !== {1'b1, 1'b1, 64'h1234_0000, 64'h9000}) begin
         n_bad++;
         $display("FAIL bypass_same_cycle: got valid=%b hit=%b phy=%h icm=%h, want 1 1 12340000 9000",
                  bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr);
      end
      bus.lookup_valid = 1'b1;
      bus.lookup_head  = 4'd9;
      tick();
      bus.lookup_valid = 1'b0;
      write_one(1'b1, 4'd9, 64'h5555_0000);
      n_vec++;
      if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr} !== {1'b1, 1'b1, 64'h1234_0000}) begin
         n_bad++;
         $display("FAIL late_write_old_value: got valid=%b hit=%b phy=%h, want 1 1 12340000",
                  bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr);
      end
      lookup_one(4'd9);
      n_vec++;
      if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr} !== {1'b1, 1'b1, 64'h5555_0000}) begin
         n_bad++;
         $display("FAIL late_write_landed: got valid=%b hit=%b phy=%h, want 1 1 55550000",
                  bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr);
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp_icm;
      logic [63:0] exp_phy;
      logic        exp_hit;
      for (int i = 0; i <= 17; i++) begin
         bus.lookup_valid = (i < 16);
         bus.lookup_head  = 4'(i);
         tick();
         n_vec++;
         if (i >= 1 && i <= 16) begin
            exp_icm = 64'(i - 1) << 12;
            exp_hit = (i - 1 == 9);
            exp_phy = exp_hit ? 64'h5555_0000 : 64'd0;
            if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr} !== {1'b1, exp_hit, exp_phy, exp_icm}) begin
               n_bad++;
               $display("FAIL b2b head %0d: got valid=%b hit=%b phy=%h icm=%h, want 1 %b %h %h",
                        i - 1, bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr, exp_hit, exp_phy, exp_icm);
            end
         end else if (bus.rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle step %0d: got rsp_valid=%b, want 0", i, bus.rsp_valid);
         end
      end
   endtask

   task automatic test_reset_inflight();
      write_one(1'b1, 4'd3, 64'hABCD_E000);
      bus.lookup_valid = 1'b1;
      bus.lookup_head  = 4'd3;
      tick();
      bus.lookup_head = 4'd4;
      #2;
      rst = 1'b0;
      bus.lookup_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         n_vec++;
         if ({bus.rsp_valid, bus.init_done} !== 2'b00) begin
            n_bad++;
            $display("FAIL inflight_dropped cycle %0d: got rsp_valid=%b done=%b, want 0 0", k, bus.rsp_valid, bus.init_done);
         end
      end
      rst = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         tick();
         n_vec++;
         if ({bus.rsp_valid, bus.init_done} !== {1'b0, k == 16}) begin
            n_bad++;
            $display("FAIL reinit cycle %0d: got rsp_valid=%b done=%b, want 0 %b", k, bus.rsp_valid, bus.init_done, k == 16);
         end
      end
      lookup_one(4'd3);
      n_vec++;
      if ({bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr} !== {1'b1, 1'b0, 64'd0, 64'h3000}) begin
         n_bad++;
         $display("FAIL reinit_cleared_3: got valid=%b hit=%b phy=%h icm=%h, want 1 0 0 3000",
                  bus.rsp_valid, bus.rsp_hit, bus.rsp_phy_addr, bus.rsp_icm_addr);
      end
   endtask

   initial begin
      bus.lookup_valid    = 1'b0;
      bus.lookup_head     = '0;
      bus.map_wr_valid    = 1'b0;
      bus.map_wr_set      = 1'b0;
      bus.map_wr_head     = '0;
      bus.map_wr_phy_addr = '0;
      test_reset();
      test_install();
      test_miss_invalidate();
      test_bypass();
      test_back_to_back();
      test_reset_inflight();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
